// File: rtl/sram_reg_bank.sv
// Falling-edge register bank: 2**ADDR_W x WIDTH words, one write port, one registered read port,
// and a clear sequencer that rewrites every word with INIT_VAL. Optional parity: SRAM_PARITY_EN.
module sram_reg_bank #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      ADDR_W   = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  input  logic              clr_req,
  output logic              busy,
`ifdef SRAM_PARITY_EN
  input  logic              inj_par,
  output logic              par_err,
`endif
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef SRAM_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [MW-1:0]     mem [DEPTH];

  logic [MW-1:0]     usr_word_c;
  logic [MW-1:0]     clr_word_c;
  logic              clearing_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [MW-1:0]     wr_word_c;
  logic [MW-1:0]     rd_word_c;

  // Stored word layout: parity bit (when enabled) above the data bits.
`ifdef SRAM_PARITY_EN
  assign usr_word_c = {(^wdata) ^ inj_par, wdata};
  assign clr_word_c = {^INIT_VAL, INIT_VAL};
`else
  assign usr_word_c = wdata;
  assign clr_word_c = INIT_VAL;
`endif

  // Clear sequencer owns the write port while busy; user writes are dropped then.
  assign clearing_c = (state == CLEAR);
  assign wr_en_c    = clearing_c | (we & ~busy);
  assign wr_addr_c  = clearing_c ? cnt : waddr;
  assign wr_word_c  = clearing_c ? clr_word_c : usr_word_c;

  // Same-edge write to the read address is forwarded to the read port.
  assign rd_word_c  = (wr_en_c && (wr_addr_c == raddr)) ? wr_word_c : mem[raddr];

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (wr_en_c) begin
      mem[wr_addr_c] <= wr_word_c;
    end
  end

  // Clear sequencer: busy for exactly DEPTH edges, then a one-cycle clr_done.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= DONE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          busy     <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; rdata holds when no read is requested.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
`ifdef SRAM_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= rd_word_c[WIDTH-1:0];
      end
`ifdef SRAM_PARITY_EN
      par_err <= re & (rd_word_c[WIDTH] != (^rd_word_c[WIDTH-1:0]));
`endif
    end
  end

endmodule

// File: tb/tb_sram_reg_bank.sv
// Scoreboard bench for sram_reg_bank (WIDTH=8, ADDR_W=4, INIT_VAL=8'hA5); parity checks
// are included when SRAM_PARITY_EN is defined.
module tb_sram_reg_bank;

  localparam logic [7:0] INIT = 8'hA5;

  logic       clk = 1'b1;
  logic       reset = 1'b1;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       re = 1'b0;
  logic [3:0] raddr = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       clr_req = 1'b0;
  logic       busy;
  logic       clr_done;
  logic       inj_par = 1'b0;
  logic       par_err;

  sram_reg_bank #(.WIDTH(8), .ADDR_W(4), .INIT_VAL(INIT)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .clr_req(clr_req), .busy(busy),
`ifdef SRAM_PARITY_EN
    .inj_par(inj_par), .par_err(par_err),
`endif
    .clr_done(clr_done)
  );

`ifndef SRAM_PARITY_EN
  assign par_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: {parity, data} per word plus the clear sequencer flags.
  logic [8:0] m_mem [16];
  logic       m_busy;
  logic       m_done;
  logic [3:0] m_cnt;
  logic       exp_rv;
  logic [8:0] q [$];       // {expected par_err, expected rdata}
  logic [7:0] last_rd;
  logic       last_pe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 9'h000;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_cnt   = 4'd0;
    exp_rv  = 1'b0;
    last_rd = 8'h00;
    last_pe = 1'b0;
    q.delete();
  endtask

  // Evaluate one falling edge against the model using the inputs currently applied.
  task automatic model_edge();
    logic       usr_w;
    logic [8:0] word;
    logic [8:0] clr_word;
    logic [8:0] usr_word;
    clr_word = {^INIT, INIT};
    usr_word = {(^wdata) ^ inj_par, wdata};
    usr_w    = we && !m_busy;
    exp_rv   = re;
    if (re) begin
      if (m_busy && m_cnt == raddr)      word = clr_word;
      else if (usr_w && waddr == raddr) word = usr_word;
      else                              word = m_mem[raddr];
      q.push_back({word[8] != (^word[7:0]), word[7:0]});
    end
    if (m_busy)     m_mem[m_cnt] = clr_word;
    else if (usr_w) m_mem[waddr] = usr_word;
    if (m_busy) begin
      if (m_cnt == 4'd15) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_cnt  = 4'd0;
      end else begin
        m_cnt = m_cnt + 4'd1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (clr_req) begin
      m_busy = 1'b1;
      m_cnt  = 4'd0;
    end
  endtask

  task automatic compare();
    logic [8:0] e;
    check("rvalid", 32'(rvalid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(m_busy));
    check("clr_done", 32'(clr_done), 32'(m_done));
    if (rvalid) begin
      if (q.size() == 0) begin
        check("q_underflow", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        last_rd = e[7:0];
        last_pe = e[8];
      end
    end
    check("rdata", 32'(rdata), 32'(last_rd));
`ifdef SRAM_PARITY_EN
    check("par_err", 32'(par_err), rvalid ? 32'(last_pe) : 32'd0);
`endif
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; clr_req = 1'b0; inj_par = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    idle_inputs(); we = 1'b1; waddr = a; wdata = d; step();
  endtask

  task automatic rd(input logic [3:0] a);
    idle_inputs(); re = 1'b1; raddr = a; step();
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle_inputs(); step();
  endtask

  int busy_len;

  initial begin
    // Reset state, before any clock edge.
    model_reset();
    #1;
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_clr_done", 32'(clr_done), 32'h0);
    @(negedge clk); #1;
    reset = 1'b0;
    step();

    // Write then read back; rvalid drops and rdata holds once re is low.
    wr(4'd5, 8'h3C);
    rd(4'd5);
    idle_inputs(); step();
    step();

    // Same-edge write and read of one address forwards the write data.
    idle_inputs(); we = 1'b1; waddr = 4'd7; wdata = 8'h11; re = 1'b1; raddr = 4'd7; step();
    rd(4'd7);
    rd(4'd0);

    // Mixed random traffic.
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      we = 1'($urandom_range(0, 1)); waddr = 4'($urandom_range(0, 15)); wdata = 8'($urandom);
      re = 1'($urandom_range(0, 1)); raddr = 4'($urandom_range(0, 15));
      step();
    end
    read_all();

    // Clear sequence with user writes and reads attempted while busy.
    idle_inputs(); clr_req = 1'b1; step();
    busy_len = 0;
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      we = 1'b1; waddr = 4'd3; wdata = 8'hFF;
      re = 1'b1; raddr = 4'(i);
      if (busy) busy_len++;
      step();
    end
    check("busy_len", 32'(busy_len), 32'd16);
    read_all();

    // clr_req held across DONE restarts the clear once IDLE is reached.
    idle_inputs(); clr_req = 1'b1;
    for (int i = 0; i < 19; i++) step();
    check("restart_busy", 32'(busy), 32'd1);
    idle_inputs();
    for (int i = 0; i < 20; i++) step();

    // Reset mid-clear aborts immediately and wipes the bank.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h40 + i));
    idle_inputs(); clr_req = 1'b1; step();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    check("abort_rvalid", 32'(rvalid), 32'd0);
    model_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    read_all();

`ifdef SRAM_PARITY_EN
    // Injected parity error is flagged, then cleared by a clean rewrite.
    idle_inputs(); we = 1'b1; waddr = 4'd2; wdata = 8'h0F; inj_par = 1'b1; step();
    rd(4'd2);
    check("par_inj", 32'(par_err), 32'd1);
    wr(4'd2, 8'h0F);
    rd(4'd2);
    check("par_clean", 32'(par_err), 32'd0);
    idle_inputs(); we = 1'b1; waddr = 4'd9; wdata = 8'h81; inj_par = 1'b1;
    re = 1'b1; raddr = 4'd9; step();
    check("par_fwd", 32'(par_err), 32'd1);
    idle_inputs(); step();
`endif

    check("q_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
